mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Signal bundle between the arbiter, its two requesters (instruction
//   fetch and data load/store) and the single-ported memory.
//   slave  : arbiter view (takes requests and memory responses, drives
//            completions, memory strobes and stall)
//   master : environment view (requesters plus memory)
//   Fetch  : if_req, if_addr -> if_rdata, if_done
//   Data   : d_read, d_write, d_addr, d_wdata, d_web -> d_rdata, d_done
//   Memory : mem_cs, mem_we, mem_addr, mem_din <- mem_dout, mem_ready
//   Misc   : stall
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_web;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_cs;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_ready;
   logic        stall;

   modport slave (
      input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_web,
             mem_dout, mem_ready,
      output if_rdata, if_done, d_rdata, d_done,
             mem_cs, mem_we, mem_addr, mem_din, stall
   );

   modport master (
      output if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_web,
             mem_dout, mem_ready,
      input  if_rdata, if_done, d_rdata, d_done,
             mem_cs, mem_we, mem_addr, mem_din, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one variable-latency memory port between instruction fetch and
//   data load/store. Data normally wins; fetch is forced through after
//   MAX_WAIT consecutive lost arbitrations.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mem_port_arbiter_if.slave (requesters, memory port, stall)
module mem_port_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  wait_cnt_reg, wait_cnt_next;
   logic        store_reg;
   logic [3:0]  mem_we_reg;
   logic        if_done_reg, d_done_reg;
   logic [31:0] if_rdata_reg, d_rdata_reg;

   logic d_req, if_pend, d_pend, force_if;
   logic grant_if, grant_d;
   logic finish_if, finish_d;

   assign d_req = bus.d_read | bus.d_write;

   // A requester still showing its done pulse has not yet dropped its
   // request, so it must not be granted a second time.
   assign if_pend  = bus.if_req & ~if_done_reg;
   assign d_pend   = d_req & ~d_done_reg;
   assign force_if = ({29'd0, wait_cnt_reg} >= 32'(MAX_WAIT));

   assign grant_if = (state_reg == IDLE) & if_pend & (~d_pend | force_if);
   assign grant_d  = (state_reg == IDLE) & d_pend & ~grant_if;

   assign finish_if = (state_reg == IF_BUSY) & bus.mem_ready;
   assign finish_d  = (state_reg == D_BUSY) & bus.mem_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (grant_if) begin
               state_next = IF_BUSY;
            end else if (grant_d) begin
               state_next = D_BUSY;
            end
         end
         IF_BUSY: if (bus.mem_ready) state_next = IDLE;
         D_BUSY:  if (bus.mem_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Starvation counter: counts data grants that overtook a waiting fetch.
   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (grant_if) begin
         wait_cnt_next = 3'd0;
      end else if (grant_d && bus.if_req && (wait_cnt_reg != 3'd7)) begin
         wait_cnt_next = wait_cnt_reg + 3'd1;
      end
   end

   // Datapath registers: access type latched at grant, completion capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_reg <= 3'd0;
         store_reg    <= 1'b0;
         mem_we_reg   <= 4'd0;
         if_done_reg  <= 1'b0;
         d_done_reg   <= 1'b0;
         if_rdata_reg <= 32'd0;
         d_rdata_reg  <= 32'd0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         if (grant_d) begin
            // Both strobes high means store; byte enables frozen here so
            // later input changes cannot disturb the access in flight.
            store_reg  <= bus.d_write;
            mem_we_reg <= bus.d_write ? bus.d_web : 4'd0;
         end
         if_done_reg <= finish_if;
         d_done_reg  <= finish_d;
         if (finish_if) begin
            if_rdata_reg <= bus.mem_dout;
         end
         if (finish_d && !store_reg) begin
            d_rdata_reg <= bus.mem_dout;
         end
      end
   end

   // Output logic
   always_comb begin
      bus.mem_cs   = 1'b0;
      bus.mem_we   = 4'd0;
      bus.mem_addr = 32'd0;
      bus.mem_din  = 32'd0;
      case (state_reg)
         IF_BUSY: begin
            bus.mem_cs   = 1'b1;
            bus.mem_addr = bus.if_addr;
         end
         D_BUSY: begin
            bus.mem_cs   = 1'b1;
            bus.mem_addr = bus.d_addr;
            bus.mem_din  = bus.d_wdata;
            bus.mem_we   = mem_we_reg;
         end
         default: ;
      endcase
   end

   assign bus.if_done  = if_done_reg;
   assign bus.d_done   = d_done_reg;
   assign bus.if_rdata = if_rdata_reg;
   assign bus.d_rdata  = d_rdata_reg;
   assign bus.stall    = (bus.if_req & ~if_done_reg) | (d_req & ~d_done_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MAX_WAIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_if[$];
   logic [31:0] exp_d[$];
   logic [31:0] last_d_rdata = 32'd0;

   // Memory model: answers lat cycles after mem_cs rises (lat >= 1).
   int   lat = 1;
   int   busy_cyc = 0;
   logic model_ready = 1'b0;
   logic force_ready = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'h0000_0013;
      return a ^ 32'h5A5A_1234;
   endfunction

   always @(posedge clk) begin
      #2;
      if (bus.mem_cs) begin
         busy_cyc++;
         model_ready = (busy_cyc > lat);
      end else begin
         busy_cyc = 0;
         model_ready = 1'b0;
      end
   end

   assign bus.mem_ready = model_ready | force_ready;
   assign bus.mem_dout  = bus.mem_ready ? mem_word(bus.mem_addr) : 32'h0;

   task automatic test_reset();
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'h0;
      bus.d_wdata = 32'h0; bus.d_web = 4'h0;
      repeat (3) @(negedge clk);
      total++; if (bus.mem_cs !== 1'b0) $display("FAIL reset_cs got=%0h want=0", bus.mem_cs); else passed++;
      total++; if (bus.mem_we !== 4'h0) $display("FAIL reset_we got=%0h want=0", bus.mem_we); else passed++;
      total++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0) $display("FAIL reset_done got=%0b%0b want=00", bus.if_done, bus.d_done); else passed++;
      total++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) $display("FAIL reset_rdata got=%h/%h want=0", bus.if_rdata, bus.d_rdata); else passed++;
      total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%0b want=0", bus.stall); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      int n;
      lat = 1;
      exp_if.push_back(mem_word(32'h100));
      bus.if_addr = 32'h100;
      bus.if_req  = 1'b1;
      @(negedge clk);
      n = 1;
      total++; if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h100) $display("FAIL fetch_cs_addr got=%0b/%h want=1/00000100", bus.mem_cs, bus.mem_addr); else passed++;
      total++; if (bus.mem_we !== 4'h0) $display("FAIL fetch_we got=%0h want=0", bus.mem_we); else passed++;
      total++; if (bus.stall !== 1'b1) $display("FAIL fetch_stall got=%0b want=1", bus.stall); else passed++;
      while (bus.if_done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (n != 3) $display("FAIL fetch_latency got=%0d want=3", n); else passed++;
      if (bus.if_done === 1'b1 && exp_if.size() > 0) begin
         logic [31:0] e;
         e = exp_if.pop_front();
         $display("txn fetch addr=00000100 rdata=%h exp=%h", bus.if_rdata, e);
         total++; if (bus.if_rdata !== e) $display("FAIL fetch_rdata got=%h want=%h", bus.if_rdata, e); else passed++;
      end
      bus.if_req = 1'b0;
      @(negedge clk);
      total++; if (bus.if_done !== 1'b0) $display("FAIL fetch_done_pulse got=%0b want=0", bus.if_done); else passed++;
      total++; if (bus.if_rdata !== 32'h13) $display("FAIL fetch_rdata_hold got=%h want=00000013", bus.if_rdata); else passed++;
   endtask

   task automatic test_load(input logic [31:0] addr, input int l);
      int n;
      lat = l;
      exp_d.push_back(mem_word(addr));
      bus.d_addr = addr;
      bus.d_read = 1'b1;
      n = 0;
      while (bus.d_done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++; if (n != l + 2) $display("FAIL load_latency got=%0d want=%0d", n, l + 2); else passed++;
      if (bus.d_done === 1'b1 && exp_d.size() > 0) begin
         logic [31:0] e;
         e = exp_d.pop_front();
         last_d_rdata = e;
         $display("txn load addr=%h rdata=%h exp=%h", addr, bus.d_rdata, e);
         total++; if (bus.d_rdata !== e) $display("FAIL load_rdata got=%h want=%h", bus.d_rdata, e); else passed++;
      end
      bus.d_read = 1'b0;
      @(negedge clk);
      total++; if (bus.d_rdata !== last_d_rdata || bus.d_done !== 1'b0) $display("FAIL load_hold got=%h/%0b want=%h/0", bus.d_rdata, bus.d_done, last_d_rdata); else passed++;
      lat = 1;
   endtask

   task automatic test_simultaneous();
      int n, order, d_order, if_order, d_cyc;
      logic stall_bad;
      lat = 1;
      bus.if_addr = 32'h180;
      bus.d_addr  = 32'h2000;
      exp_d.push_back(mem_word(32'h2000));
      exp_if.push_back(mem_word(32'h180));
      bus.if_req = 1'b1;
      bus.d_read = 1'b1;
      n = 0; order = 0; d_order = -1; if_order = -1; d_cyc = -10;
      stall_bad = 1'b0;
      while (if_order < 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.if_done !== 1'b1 && bus.stall !== 1'b1) stall_bad = 1'b1;
         if (n == d_cyc + 1) begin
            total++; if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h180) $display("FAIL simul_fetch_grant got=%0b/%h want=1/00000180", bus.mem_cs, bus.mem_addr); else passed++;
         end
         if (bus.d_done === 1'b1 && exp_d.size() > 0) begin
            logic [31:0] e;
            e = exp_d.pop_front();
            last_d_rdata = e;
            d_order = order++;
            d_cyc = n;
            $display("txn load addr=00002000 rdata=%h exp=%h", bus.d_rdata, e);
            total++; if (bus.d_rdata !== e) $display("FAIL simul_d_rdata got=%h want=%h", bus.d_rdata, e); else passed++;
            bus.d_read = 1'b0;
         end
         if (bus.if_done === 1'b1 && exp_if.size() > 0) begin
            logic [31:0] e;
            e = exp_if.pop_front();
            if_order = order++;
            $display("txn fetch addr=00000180 rdata=%h exp=%h", bus.if_rdata, e);
            total++; if (bus.if_rdata !== e) $display("FAIL simul_if_rdata got=%h want=%h", bus.if_rdata, e); else passed++;
            bus.if_req = 1'b0;
         end
      end
      total++; if (d_order != 0 || if_order != 1) $display("FAIL simul_order got=d%0d/if%0d want=d0/if1", d_order, if_order); else passed++;
      total++; if (stall_bad !== 1'b0) $display("FAIL simul_stall got=dropped want=held"); else passed++;
      bus.if_req = 1'b0;
      bus.d_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store();
      int n, busy, dones;
      logic we_bad;
      lat = 2;
      bus.d_addr  = 32'h3000;
      bus.d_wdata = 32'hDEAD_BEEF;
      bus.d_web   = 4'b0011;
      bus.d_read  = 1'b1;   // both strobes: must behave as a store
      bus.d_write = 1'b1;
      busy = 0; dones = 0; we_bad = 1'b0;
      for (n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.mem_cs === 1'b1) begin
            busy++;
            if (bus.mem_we !== 4'b0011 || bus.mem_din !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h3000) we_bad = 1'b1;
            bus.d_web = 4'b1100;   // must not reach mem_we mid-access
         end
         if (bus.d_done === 1'b1) begin
            dones++;
            $display("txn store addr=00003000 wdata=deadbeef d_rdata=%h", bus.d_rdata);
            bus.d_read = 1'b0;
            bus.d_write = 1'b0;
         end
      end
      total++; if (we_bad !== 1'b0) $display("FAIL store_we got=changed want=0011"); else passed++;
      total++; if (busy != 3) $display("FAIL store_busy_cycles got=%0d want=3", busy); else passed++;
      total++; if (dones != 1) $display("FAIL store_done_count got=%0d want=1", dones); else passed++;
      total++; if (bus.d_rdata !== last_d_rdata) $display("FAIL store_rdata got=%h want=%h", bus.d_rdata, last_d_rdata); else passed++;
      bus.d_web = 4'h0;
      lat = 1;
   endtask

   task automatic test_starvation();
      int n, grants, grants_at_fetch;
      logic prev_cs, fetch_granted, fin;
      lat = 1;
      bus.if_addr = 32'h300;
      bus.d_addr  = 32'h4000;
      bus.d_read  = 1'b1;
      bus.if_req  = 1'b1;
      n = 0; grants = 0; grants_at_fetch = -1;
      prev_cs = 1'b0; fetch_granted = 1'b0; fin = 1'b0;
      while (!fin && n < 200) begin
         @(negedge clk);
         n++;
         if (bus.mem_cs === 1'b1 && prev_cs !== 1'b1) begin
            if (bus.mem_addr === 32'h4000) begin
               grants++;
               exp_d.push_back(mem_word(32'h4000));
            end else if (bus.mem_addr === 32'h300) begin
               fetch_granted = 1'b1;
               grants_at_fetch = grants;
               exp_if.push_back(mem_word(32'h300));
               total++; if (dut.wait_cnt_reg !== 3'd0) $display("FAIL starve_wait_clear got=%0d want=0", dut.wait_cnt_reg); else passed++;
            end
         end
         prev_cs = bus.mem_cs;
         if (bus.d_done === 1'b1 && exp_d.size() > 0) begin
            logic [31:0] e;
            e = exp_d.pop_front();
            last_d_rdata = e;
            $display("txn load addr=00004000 rdata=%h exp=%h", bus.d_rdata, e);
            total++; if (bus.d_rdata !== e) $display("FAIL starve_d_rdata got=%h want=%h", bus.d_rdata, e); else passed++;
         end
         if (bus.if_done === 1'b1 && exp_if.size() > 0) begin
            logic [31:0] e;
            e = exp_if.pop_front();
            $display("txn fetch addr=00000300 rdata=%h exp=%h", bus.if_rdata, e);
            total++; if (bus.if_rdata !== e) $display("FAIL starve_if_rdata got=%h want=%h", bus.if_rdata, e); else passed++;
            bus.if_req = 1'b0;
            fin = 1'b1;
         end else if (!fetch_granted) begin
            // Fetcher withdraws during each data completion cycle and
            // re-asserts afterwards, so data keeps winning until forced.
            bus.if_req = !bus.d_done;
         end
      end
      total++; if (grants_at_fetch != 4) $display("FAIL starve_grants got=%0d want=4", grants_at_fetch); else passed++;
      // Pending data request is served next.
      exp_d.push_back(mem_word(32'h4000));
      n = 0;
      while (bus.d_done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (bus.d_done !== 1'b1) $display("FAIL starve_final_done got=0 want=1"); else passed++;
      if (bus.d_done === 1'b1 && exp_d.size() > 0) begin
         logic [31:0] e;
         e = exp_d.pop_front();
         last_d_rdata = e;
         $display("txn load addr=00004000 rdata=%h exp=%h", bus.d_rdata, e);
      end
      bus.d_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic stray;
      lat = 20;
      bus.d_addr = 32'h5000;
      bus.d_read = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (bus.mem_cs !== 1'b1) $display("FAIL rstmid_busy got=%0b want=1", bus.mem_cs); else passed++;
      rst = 1'b1;
      #1;
      total++; if (bus.mem_cs !== 1'b0 || bus.mem_we !== 4'h0) $display("FAIL rstmid_cs got=%0b/%0h want=0/0", bus.mem_cs, bus.mem_we); else passed++;
      @(negedge clk);
      rst = 1'b0;
      bus.d_read = 1'b0;
      $display("txn reset_abort addr=00005000");
      force_ready = 1'b1;
      stray = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.d_done !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_cs !== 1'b0) stray = 1'b1;
      end
      force_ready = 1'b0;
      total++; if (stray !== 1'b0) $display("FAIL rstmid_stray got=activity want=none"); else passed++;
      total++; if (bus.d_rdata !== 32'h0) $display("FAIL rstmid_rdata got=%h want=00000000", bus.d_rdata); else passed++;
      last_d_rdata = 32'h0;
      lat = 1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_load(32'h2000, 3);
      test_simultaneous();
      test_store();
      test_starvation();
      test_reset_mid();
      test_single_fetch();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
